hmc960_ctrl: RTL and testbench

Command sequencer and arbiter in front of the hmc960 serial engine. It shares the single HMC960 link between a host register-access port and a low-latency gain-update port. It builds the 32-bit frames, pulses xfer_begin, and tracks completion from the engine's cs line. It also enforces the inter-frame gap, detects stalled transfers, and returns read data.

---
 rtl/hmc960_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hmc960_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hmc960_ctrl.sv
// hmc960_ctrl: frame sequencer/arbiter sharing the HMC960 link between host and gain ports; HMC960_CTRL_READ_EN enables two-frame host reads
module hmc960_ctrl #(
  parameter logic [2:0] CHIP_ADDR     = 3'b110,
  parameter logic [4:0] GAIN_REG      = 5'd1,
  parameter int         GAP_CYCLES    = 16,
  parameter int         START_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [4:0]  host_addr,
  input  logic [23:0] host_wdata,
  output logic        host_ack,
  output logic [23:0] host_rdata,
  input  logic        gain_valid,
  input  logic [23:0] gain_word,
  output logic        gain_pending,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr,
  output logic        xfer_begin,
  output logic [31:0] tx_data,
  input  logic        spi_cs,
  input  logic [31:0] spi_rx_data
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WSTART = 3'd2;
  localparam logic [2:0] S_WDONE  = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [7:0]    GAP_MAX = 8'(GAP_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    gap_q, gap_d;
  logic [TW-1:0] to_q, to_d;
  logic [23:0]   gain_q, gain_d;
  logic          pend_q, pend_d;
  logic [31:0]   tx_q, tx_d;
  logic          host_q, host_d;
  logic          rd_q, rd_d;
  logic          ph2_q, ph2_d;
  logic          ack_q, ack_d;
  logic [23:0]   rdata_q, rdata_d;
  logic          terr_q, terr_d;
  logic          cs_meta_q, cs_q;
  logic          unused_rx_lsb;

  assign unused_rx_lsb = ^spi_rx_data[7:0];

  assign busy         = state_q != S_IDLE;
  assign xfer_begin   = state_q == S_LAUNCH;
  assign host_ack     = ack_q;
  assign host_rdata   = rdata_q;
  assign gain_pending = pend_q;
  assign timeout_err  = terr_q;
  assign tx_data      = tx_q;

  // cs comes from the engine's serial clock domain; idle high so reset to 1
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta_q <= 1'b1;
      cs_q      <= 1'b1;
    end else begin
      cs_meta_q <= spi_cs;
      cs_q      <= cs_meta_q;
    end
  end

  // arbitration, frame building and completion tracking
  always_comb begin
    state_d = state_q;
    gap_d   = (gap_q == GAP_MAX) ? gap_q : gap_q + 8'd1;
    to_d    = to_q;
    gain_d  = gain_valid ? gain_word : gain_q;
    pend_d  = gain_valid | pend_q;
    tx_d    = tx_q;
    host_d  = host_q;
    rd_d    = rd_q;
    ph2_d   = ph2_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    terr_d  = terr_q & ~err_clr;
    case (state_q)
      S_IDLE: if (gap_q == GAP_MAX) begin
        if (pend_q) begin
          tx_d    = {gain_q, GAIN_REG, CHIP_ADDR};
          pend_d  = gain_valid;
          host_d  = 1'b0;
          rd_d    = 1'b0;
          ph2_d   = 1'b0;
          state_d = S_LAUNCH;
        end else if (host_req && !gain_valid && !ack_q) begin
          host_d = 1'b1;
          rd_d   = !host_wr;
          ph2_d  = 1'b0;
`ifdef HMC960_CTRL_READ_EN
          tx_d    = host_wr ? {host_wdata, host_addr, CHIP_ADDR} : {19'd0, host_addr, 5'd0, CHIP_ADDR};
          state_d = S_LAUNCH;
`else
          tx_d    = host_wr ? {host_wdata, host_addr, CHIP_ADDR} : tx_q;
          ph2_d   = !host_wr;
          rdata_d = host_wr ? rdata_q : 24'd0;
          state_d = host_wr ? S_LAUNCH : S_GAP;
`endif
        end
      end
      S_LAUNCH: begin
        to_d    = '0;
        state_d = S_WSTART;
      end
      S_WSTART: if (!cs_q) begin
        state_d = S_WDONE;
      end else if (to_q == TO_LAST) begin
        terr_d  = 1'b1;
        ack_d   = host_q;
        rdata_d = host_q ? 24'hFFFFFF : rdata_q;
        state_d = S_IDLE;
      end else begin
        to_d = to_q + TW'(1);
      end
      S_WDONE: if (cs_q) begin
        gap_d   = 8'd0;
        rdata_d = (rd_q && ph2_q) ? spi_rx_data[31:8] : rdata_q;
        state_d = S_GAP;
      end
      S_GAP: if (gap_q == GAP_MAX) begin
        if (host_q && rd_q && !ph2_q) begin
          ph2_d   = 1'b1;
          tx_d    = {24'd0, 5'd0, CHIP_ADDR};
          state_d = S_LAUNCH;
        end else begin
          ack_d   = host_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers; a reset mid-frame simply abandons the operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gap_q   <= GAP_MAX;
      to_q    <= '0;
      gain_q  <= '0;
      pend_q  <= 1'b0;
      tx_q    <= '0;
      host_q  <= 1'b0;
      rd_q    <= 1'b0;
      ph2_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      gain_q  <= gain_d;
      pend_q  <= pend_d;
      tx_q    <= tx_d;
      host_q  <= host_d;
      rd_q    <= rd_d;
      ph2_q   <= ph2_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
    end
  end
endmodule

// File: tb/tb_hmc960_ctrl.sv
// tb_hmc960_ctrl: directed self-checking bench for hmc960_ctrl with a simple engine responder
module tb_hmc960_ctrl;
  localparam int GAP = 16;
  localparam int TOUT = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_req, host_wr;
  logic [4:0]  host_addr;
  logic [23:0] host_wdata;
  logic        host_ack;
  logic [23:0] host_rdata;
  logic        gain_valid;
  logic [23:0] gain_word;
  logic        gain_pending, busy, timeout_err, err_clr, xfer_begin;
  logic [31:0] tx_data;
  logic        spi_cs;
  logic [31:0] spi_rx_data;

  int n_cmp = 0, n_bad = 0, n_xfer = 0, n_ack = 0, cyc = 0;
  int ack_cyc = 0, cs_rise_cyc = 0;
  logic [31:0] frames [0:63];
  int xfer_cyc [0:63];
  bit eng_en = 1'b1;

  hmc960_ctrl dut (
    .clk(clk), .reset(reset), .host_req(host_req), .host_wr(host_wr),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .gain_valid(gain_valid), .gain_word(gain_word),
    .gain_pending(gain_pending), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr), .xfer_begin(xfer_begin), .tx_data(tx_data),
    .spi_cs(spi_cs), .spi_rx_data(spi_rx_data)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (xfer_begin && n_xfer < 64) begin
      frames[n_xfer] = tx_data;
      xfer_cyc[n_xfer] = cyc;
      n_xfer++;
    end
    if (host_ack) begin
      n_ack++;
      ack_cyc = cyc;
    end
  end

  initial begin
    spi_cs = 1'b1;
    spi_rx_data = 32'h12345600;
    forever begin
      @(negedge clk);
      if (xfer_begin && eng_en) begin
        repeat (3) @(negedge clk);
        spi_cs = 1'b0;
        repeat (20) @(negedge clk);
        spi_cs = 1'b1;
        cs_rise_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_xfer(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      ok = xfer_begin;
    end
  endtask

  task automatic wait_ack(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      ok = host_ack;
    end
  endtask

  task automatic wait_idle(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      ok = !busy;
    end
  endtask

  initial begin
    logic ok;
    int nx0, na0, t0;
    reset = 1'b1; host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
    gain_valid = 1'b0; gain_word = '0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_xfer", xfer_begin, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_tx", tx_data, 0);
    chk("rst_pend", gain_pending, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_rdata", host_rdata, 0);
    reset = 1'b0;
    repeat (2) tick();

    // 1: host write
    nx0 = n_xfer;
    host_wr = 1'b1; host_addr = 5'h03; host_wdata = 24'h00ABCD; host_req = 1'b1;
    wait_xfer(50, ok);
    chk("t1_xfer_seen", ok, 1);
    chk("t1_tx", tx_data, 32'h00ABCD1E);
    tick();
    chk("t1_xfer_pulse_len", xfer_begin, 0);
    chk("t1_busy_mid", busy, 1);
    wait_ack(200, ok);
    host_req = 1'b0;
    chk("t1_ack_seen", ok, 1);
    chk("t1_ack_after_gap", (ack_cyc - cs_rise_cyc >= GAP) && (ack_cyc - cs_rise_cyc <= GAP + 6), 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_frames", n_xfer - nx0, 1);
    tick();
    chk("t1_ack_one_cycle", host_ack, 0);

    // 2: gain updates during a host frame, latest wins
    host_addr = 5'h04; host_wdata = 24'h000042; host_req = 1'b1;
    wait_xfer(50, ok);
    chk("t2_host_xfer", ok, 1);
    nx0 = n_xfer;
    tick();
    gain_valid = 1'b1; gain_word = 24'h000111;
    tick();
    gain_word = 24'h000222;
    tick();
    gain_valid = 1'b0;
    chk("t2_pend_set", gain_pending, 1);
    wait_ack(200, ok);
    host_req = 1'b0;
    chk("t2_host_ack", ok, 1);
    wait_xfer(50, ok);
    chk("t2_gain_xfer", ok, 1);
    chk("t2_gain_frame", tx_data, 32'h0002220E);
    chk("t2_pend_clr", gain_pending, 0);
    wait_idle(200, ok);
    chk("t2_idle", ok, 1);
    repeat (40) tick();
    chk("t2_single_gain", n_xfer - nx0, 1);

    // 3: simultaneous host and gain in IDLE, gain goes first
    nx0 = n_xfer;
    host_addr = 5'h07; host_wdata = 24'h00BEEF; host_req = 1'b1;
    gain_valid = 1'b1; gain_word = 24'h000333;
    tick();
    gain_valid = 1'b0;
    wait_ack(400, ok);
    host_req = 1'b0;
    chk("t3_ack", ok, 1);
    chk("t3_frames", n_xfer - nx0, 2);
    chk("t3_first_gain", frames[nx0], 32'h0003330E);
    chk("t3_second_host", frames[nx0+1], 32'h00BEEF3E);
    chk("t3_spacing", (xfer_cyc[nx0+1] - xfer_cyc[nx0]) >= GAP, 1);

    // 4: start timeout
    eng_en = 1'b0;
    host_addr = 5'h05; host_wdata = 24'h000055; host_req = 1'b1;
    wait_xfer(50, ok);
    chk("t4_xfer", ok, 1);
    t0 = cyc;
    repeat (TOUT - 10) tick();
    chk("t4_no_early_err", timeout_err, 0);
    wait_ack(40, ok);
    host_req = 1'b0;
    chk("t4_ack", ok, 1);
    chk("t4_ack_time", (ack_cyc - t0 >= TOUT) && (ack_cyc - t0 <= TOUT + 4), 1);
    chk("t4_rdata", host_rdata, 24'hFFFFFF);
    repeat (3) tick();
    chk("t4_err_sticky", timeout_err, 1);
    chk("t4_idle", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr", timeout_err, 0);
    eng_en = 1'b1;
    repeat (5) tick();

    // 5: host read
    nx0 = n_xfer;
    host_wr = 1'b0; host_addr = 5'h02; host_req = 1'b1;
    wait_ack(400, ok);
    host_req = 1'b0;
    chk("t5_ack", ok, 1);
`ifdef HMC960_CTRL_READ_EN
    chk("t5_frames", n_xfer - nx0, 2);
    chk("t5_phase1", frames[nx0], 32'h00000206);
    chk("t5_phase2", frames[nx0+1], 32'h00000006);
    chk("t5_rdata", host_rdata, 24'h123456);
`else
    chk("t5_no_frames", n_xfer - nx0, 0);
    chk("t5_rdata_zero", host_rdata, 24'h000000);
`endif
    host_wr = 1'b1;
    wait_idle(50, ok);
    repeat (5) tick();

    // 6: reset during WAIT_DONE
    host_addr = 5'h01; host_wdata = 24'h0000AA; host_req = 1'b1;
    wait_xfer(50, ok);
    chk("t6_xfer", ok, 1);
    repeat (8) tick();
    gain_valid = 1'b1; gain_word = 24'h000444;
    tick();
    gain_valid = 1'b0;
    chk("t6_pend_before", gain_pending, 1);
    chk("t6_busy_before", busy, 1);
    repeat (2) tick();
    reset = 1'b1; host_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_xfer_low", xfer_begin, 0);
    chk("t6_ack_low", host_ack, 0);
    chk("t6_pend_clr", gain_pending, 0);
    chk("t6_tx_clr", tx_data, 0);
    na0 = n_ack;
    nx0 = n_xfer;
    repeat (60) tick();
    chk("t6_no_ack", n_ack - na0, 0);
    chk("t6_no_frame", n_xfer - nx0, 0);
    chk("t6_still_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
